// File: rtl/byte_mem_bridge_if.sv
// Bus bundles for the word-request side (control unit <-> bridge) and the
// byte-wide physical memory side (bridge <-> memory).

interface mem_word_if;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_error;

  modport master (
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    input  mem_rdata, mem_resp, mem_error
  );

  modport slave (
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    output mem_rdata, mem_resp, mem_error
  );
endinterface

interface pmem_byte_if;
  logic [15:0] pmem_address;
  logic [7:0]  pmem_wdata;
  logic [7:0]  pmem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;

  modport master (
    output pmem_address, pmem_wdata, pmem_read, pmem_write,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_address, pmem_wdata, pmem_read, pmem_write,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/byte_mem_bridge.sv
// Serialises 16-bit word requests into one or two byte beats on an 8-bit
// memory port, with a per-beat wait-state timeout and a sticky error flag.

module byte_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  mem_word_if.slave  mem_if,
  pmem_byte_if.master pmem_if
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_MID,
    ST_HI,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_rdata;
  logic              r_is_read;
  logic              r_need_hi;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_error;

  logic              w_accept;
  logic              w_strobe;
  logic              w_timeout;
  logic              w_beat_done;
  logic [7:0]        w_beat_byte;

  assign w_accept    = (r_state == ST_IDLE) && (mem_if.mem_read || mem_if.mem_write);
  assign w_strobe    = (r_state == ST_LO) || (r_state == ST_HI);
  // A beat that hits its wait budget is closed out exactly like a real response.
  assign w_timeout   = (TIMEOUT > 0) && w_strobe && !pmem_if.pmem_resp && (r_cnt == CNT_LAST);
  assign w_beat_done = w_strobe && (pmem_if.pmem_resp || w_timeout);
  assign w_beat_byte = pmem_if.pmem_resp ? pmem_if.pmem_rdata : 8'hFF;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_if.mem_read) begin
          w_next_state = ST_LO;
        end else if (mem_if.mem_write) begin
          if (mem_if.mem_byte_enable[0])      w_next_state = ST_LO;
          else if (mem_if.mem_byte_enable[1]) w_next_state = ST_HI;
          else                                w_next_state = ST_DONE;
        end
      end
      ST_LO:   if (w_beat_done) w_next_state = r_need_hi ? ST_MID : ST_DONE;
      ST_MID:  w_next_state = ST_HI;
      ST_HI:   if (w_beat_done) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_is_read <= 1'b0;
      r_need_hi <= 1'b0;
      r_cnt     <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= mem_if.mem_address & 16'hFFFE;
        r_wdata   <= mem_if.mem_wdata;
        r_is_read <= mem_if.mem_read;
        r_need_hi <= mem_if.mem_read || mem_if.mem_byte_enable[1];
      end

      // Counts wait cycles of the current beat; zero whenever no beat is pending.
      if (w_strobe && !w_beat_done) r_cnt <= r_cnt + 1'b1;
      else                          r_cnt <= '0;

      if (w_beat_done && r_is_read) begin
        if (r_state == ST_LO) r_rdata[7:0]  <= w_beat_byte;
        else                  r_rdata[15:8] <= w_beat_byte;
      end

      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign mem_if.mem_rdata     = r_rdata;
  assign mem_if.mem_resp      = (r_state == ST_DONE);
  assign mem_if.mem_error     = r_error;

  assign pmem_if.pmem_address = r_addr | {15'd0, (r_state == ST_HI)};
  assign pmem_if.pmem_wdata   = (r_state == ST_HI) ? r_wdata[15:8] : r_wdata[7:0];
  assign pmem_if.pmem_read    = w_strobe && r_is_read;
  assign pmem_if.pmem_write   = w_strobe && !r_is_read;

endmodule

// File: tb/tb_byte_mem_bridge.sv
// Self-checking bench for byte_mem_bridge: byte-memory model with wait states,
// a beat scoreboard, a table of word transactions and reset/timeout sequences.

module tb_byte_mem_bridge;

  logic clk;
  logic rst;

  mem_word_if  mif ();
  pmem_byte_if pif ();

  byte_mem_bridge #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_if  (mif),
    .pmem_if (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
  } beat_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          waits;
    logic [15:0] exp_rdata;
    int          exp_lat;
    logic [31:0] exp_mask;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       exp_beats[$];
  logic [7:0]  mem_wr[logic [15:0]];
  int          waits = 0;
  bit          hang_hi = 1'b0;
  int          wcnt = 0;
  bit          prev_wait = 1'b0;
  logic [25:0] prev_sig = '0;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [15:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    if (a == 16'h1234) return 8'hCD;
    if (a == 16'h1235) return 8'hAB;
    return a[7:0] ^ 8'h5A;
  endfunction

  // One clock cycle: at the falling edge, play the memory side for this cycle
  // and score any beat that completes at the next rising edge.
  task automatic step();
    beat_t       b;
    logic        strobe;
    logic [25:0] sig;
    @(negedge clk);
    strobe = pif.pmem_read || pif.pmem_write;
    sig    = {pif.pmem_address, pif.pmem_read, pif.pmem_write, pif.pmem_wdata};
    if (strobe) begin
      pif.pmem_rdata = byte_at(pif.pmem_address);
      pif.pmem_resp  = (wcnt >= waits) && !(hang_hi && pif.pmem_address[0]);
      if (prev_wait) check("strobe_hold", {6'd0, sig}, {6'd0, prev_sig});
      if (pif.pmem_resp) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL beat_unexpected: got beat at %h (write=%b), expected none",
                   pif.pmem_address, pif.pmem_write);
        end else begin
          b = exp_beats.pop_front();
          check("beat_addr", {16'd0, pif.pmem_address}, {16'd0, b.addr});
          check("beat_op", {31'd0, pif.pmem_write}, {31'd0, b.wr});
          if (b.wr) begin
            check("beat_wdata", {24'd0, pif.pmem_wdata}, {24'd0, b.data});
            mem_wr[pif.pmem_address] = pif.pmem_wdata;
          end
        end
        wcnt      = 0;
        prev_wait = 1'b0;
      end else begin
        wcnt++;
        prev_wait = 1'b1;
      end
      prev_sig = sig;
    end else begin
      pif.pmem_resp = 1'b0;
      wcnt          = 0;
      prev_wait     = 1'b0;
    end
  endtask

  // Issue one word request, queue its expected beats, wait (bounded) for
  // mem_resp and compare latency, strobe-cycle pattern, read data and error.
  task automatic run_txn(input string name, input vec_t v, input bit hang, input bit exp_err);
    int          lat;
    logic [31:0] mask;
    waits   = v.waits;
    hang_hi = hang;
    if (v.rd) begin
      exp_beats.push_back('{v.addr & 16'hFFFE, 8'h00, 1'b0});
      if (!hang) exp_beats.push_back('{v.addr | 16'h0001, 8'h00, 1'b0});
    end else if (v.wr) begin
      if (v.be[0]) exp_beats.push_back('{v.addr & 16'hFFFE, v.wdata[7:0], 1'b1});
      if (v.be[1]) exp_beats.push_back('{v.addr | 16'h0001, v.wdata[15:8], 1'b1});
    end
    mif.mem_read        = v.rd;
    mif.mem_write       = v.wr;
    mif.mem_address     = v.addr;
    mif.mem_wdata       = v.wdata;
    mif.mem_byte_enable = v.be;
    lat  = 0;
    mask = '0;
    for (int c = 1; c <= 64; c++) begin
      step();
      if ((pif.pmem_read || pif.pmem_write) && c < 32) mask[c] = 1'b1;
      if (mif.mem_resp) begin
        lat = c;
        break;
      end
    end
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
    check({name, "_latency"}, lat, v.exp_lat);
    check({name, "_strobe_cycles"}, mask, v.exp_mask);
    check({name, "_rdata"}, {16'd0, mif.mem_rdata}, {16'd0, v.exp_rdata});
    check({name, "_error"}, {31'd0, mif.mem_error}, {31'd0, exp_err});
    check({name, "_beats_left"}, exp_beats.size(), 0);
    exp_beats.delete();
    step();
    check({name, "_resp_one_cycle"}, {31'd0, mif.mem_resp}, 32'd0);
  endtask

  initial begin
    int   n_resp;
    vec_t v;

    rst                 = 1'b1;
    mif.mem_read        = 1'b0;
    mif.mem_write       = 1'b0;
    mif.mem_address     = '0;
    mif.mem_wdata       = '0;
    mif.mem_byte_enable = '0;
    pif.pmem_resp       = 1'b0;
    pif.pmem_rdata      = '0;

    //            rd    wr    addr      wdata     be     w  rdata     lat mask
    vecs[0]  = '{1'b1, 1'b0, 16'h1235, 16'h0000, 2'b00, 0, 16'hABCD, 4,  32'h00A};
    vecs[1]  = '{1'b1, 1'b1, 16'h1234, 16'h0000, 2'b11, 0, 16'hABCD, 4,  32'h00A};
    vecs[2]  = '{1'b0, 1'b1, 16'h2000, 16'hBEEF, 2'b11, 0, 16'hABCD, 4,  32'h00A};
    vecs[3]  = '{1'b0, 1'b1, 16'h2000, 16'hBEEF, 2'b10, 0, 16'hABCD, 2,  32'h002};
    vecs[4]  = '{1'b0, 1'b1, 16'h2000, 16'hBEEF, 2'b00, 0, 16'hABCD, 1,  32'h000};
    vecs[5]  = '{1'b0, 1'b1, 16'h3000, 16'h1234, 2'b01, 0, 16'hABCD, 2,  32'h002};
    vecs[6]  = '{1'b0, 1'b1, 16'h4000, 16'hA55A, 2'b11, 2, 16'hABCD, 8,  32'h0EE};
    vecs[7]  = '{1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00, 0, 16'hBEEF, 4,  32'h00A};
    vecs[8]  = '{1'b1, 1'b0, 16'h3000, 16'h0000, 2'b00, 1, 16'h5B34, 6,  32'h036};
    vecs[9]  = '{1'b1, 1'b0, 16'h4001, 16'h0000, 2'b00, 3, 16'hA55A, 10, 32'h3DE};
    vecs[10] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 0, 16'hABCD, 4,  32'h00A};

    step();
    step();
    check("rst_mem_resp",     {31'd0, mif.mem_resp},      32'd0);
    check("rst_pmem_read",    {31'd0, pif.pmem_read},     32'd0);
    check("rst_pmem_write",   {31'd0, pif.pmem_write},    32'd0);
    check("rst_pmem_address", {16'd0, pif.pmem_address},  32'd0);
    check("rst_pmem_wdata",   {24'd0, pif.pmem_wdata},    32'd0);
    check("rst_mem_rdata",    {16'd0, mif.mem_rdata},     32'd0);
    check("rst_mem_error",    {31'd0, mif.mem_error},     32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);
    end

    // Reset while a low beat is stalled: strobe must drop without a clock edge.
    waits           = 3;
    hang_hi         = 1'b0;
    mif.mem_address = 16'h1234;
    mif.mem_read    = 1'b1;
    step();
    check("rst_lo_strobe_before", {31'd0, pif.pmem_read}, 32'd1);
    rst          = 1'b1;
    mif.mem_read = 1'b0;
    #1;
    check("rst_lo_strobe_async", {30'd0, pif.pmem_read, pif.pmem_write}, 32'd0);
    step();
    rst = 1'b0;

    // Reset in MID: transaction is discarded, no completion pulse.
    waits = 0;
    exp_beats.push_back('{16'h1234, 8'h00, 1'b0});
    mif.mem_address = 16'h1235;
    mif.mem_read    = 1'b1;
    step();
    step();
    check("rst_mid_gap", {30'd0, pif.pmem_read, pif.pmem_write}, 32'd0);
    rst          = 1'b1;
    mif.mem_read = 1'b0;
    #1;
    check("rst_mid_strobes", {30'd0, pif.pmem_read, pif.pmem_write}, 32'd0);
    check("rst_mid_resp", {31'd0, mif.mem_resp}, 32'd0);
    step();
    rst    = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mif.mem_resp) n_resp++;
    end
    check("rst_mid_no_resp", n_resp, 0);
    check("rst_mid_rdata", {16'd0, mif.mem_rdata}, 32'd0);
    check("rst_mid_beats_left", exp_beats.size(), 0);
    exp_beats.delete();

    v = '{1'b1, 1'b0, 16'h1235, 16'h0000, 2'b00, 0, 16'hABCD, 4, 32'h00A};
    run_txn("post_rst_read", v, 1'b0, 1'b0);

    // High beat never answered: abandoned after 4 strobe cycles, byte reads as FF.
    v = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 0, 16'hFFCD, 7, 32'h07A};
    run_txn("timeout_hi", v, 1'b1, 1'b1);

    v = '{1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00, 0, 16'hBEEF, 4, 32'h00A};
    run_txn("sticky_err_read", v, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
